// File: rtl/alu_job_scheduler.sv
// alu_job_scheduler: in-order job queue in front of a combinational ALU and a
// multi-cycle shift-add multiplier. Jobs {opcode, A, B} are buffered in a
// DEPTH-entry FIFO, popped one at a time into issue registers, and routed to
// the ALU or, for MUL_OPCODE, to the multiplier. The result is latched into a
// display register and a one-cycle result_valid pulse follows.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   push, push_job    enqueue strobe and job {opcode[19:16], A[15:8], B[7:0]}
//   alu_en            high during the ALU issue cycle
//   alu_opcode/a/b    issue registers, held until the next pop
//   alu_result        combinational ALU output
//   mul_start         one-cycle multiplier start pulse
//   mul_done          multiplier completion (level or pulse)
//   mul_product       multiplier product
//   result            last completed result
//   result_valid      one-cycle pulse when result updates
//   count/full/empty  FIFO occupancy
//   overflow          sticky: a push was dropped
//   timeout_err       sticky: multiplier did not answer within MUL_TIMEOUT
//   state             FSM state code for the 7-segment display
//   jobs_done         saturating count of completed jobs (only when
//                     ALU_SCHED_STATS_EN is defined)

module alu_job_scheduler #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [3:0]  MUL_OPCODE  = 4'hF,
    parameter int unsigned MUL_TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [19:0]              push_job,
    output logic                     alu_en,
    output logic [3:0]               alu_opcode,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    input  logic [15:0]              alu_result,
    output logic                     mul_start,
    input  logic                     mul_done,
    input  logic [15:0]              mul_product,
    output logic [15:0]              result,
    output logic                     result_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     timeout_err,
    output logic [3:0]               state
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [7:0]               jobs_done
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = $clog2(MUL_TIMEOUT) + 1;

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StAluIssue  = 4'd1,
        StMulStart  = 4'd2,
        StMulWait   = 4'd3,
        StWriteback = 4'd4
    } state_e;

    state_e            state_q, state_d;
    logic [19:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              timeout_err_q, timeout_err_d;
    logic [15:0]       result_q, result_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              pop;
    logic              push_ok;
    logic [19:0]       head_job;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign head_job = mem_q[rd_ptr_q];

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop);

    // FIFO pointer/occupancy next state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_job;
        end
    end

    // FSM next state and outputs.
    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;
        opcode_d      = opcode_q;
        a_d           = a_q;
        b_d           = b_q;
        tmr_d         = tmr_q;
        pop           = 1'b0;
        alu_en        = 1'b0;
        mul_start     = 1'b0;
        result_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    opcode_d = head_job[19:16];
                    a_d      = head_job[15:8];
                    b_d      = head_job[7:0];
                    state_d  = (head_job[19:16] == MUL_OPCODE) ? StMulStart : StAluIssue;
                end
            end
            StAluIssue: begin
                alu_en   = 1'b1;
                result_d = alu_result;
                state_d  = StWriteback;
            end
            StMulStart: begin
                // mul_done is not looked at here, so a stale done is ignored.
                mul_start = 1'b1;
                tmr_d     = '0;
                state_d   = StMulWait;
            end
            StMulWait: begin
                if (mul_done) begin
                    result_d = mul_product;
                    state_d  = StWriteback;
                end else if (tmr_q == TmrW'(MUL_TIMEOUT - 1)) begin
                    result_d      = 16'hDEAD;
                    timeout_err_d = 1'b1;
                    state_d       = StWriteback;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StWriteback: begin
                result_valid = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            result_q      <= 16'h0000;
            opcode_q      <= 4'h0;
            a_q           <= 8'h00;
            b_q           <= 8'h00;
            tmr_q         <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            result_q      <= result_d;
            opcode_q      <= opcode_d;
            a_q           <= a_d;
            b_q           <= b_d;
            tmr_q         <= tmr_d;
        end
    end

`ifdef ALU_SCHED_STATS_EN
    logic [7:0] jobs_done_q, jobs_done_d;

    // Every writeback counts, including timed-out multiplies; saturates.
    always_comb begin
        jobs_done_d = jobs_done_q;
        if (state_q == StWriteback && jobs_done_q != 8'hFF) begin
            jobs_done_d = jobs_done_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jobs_done_q <= 8'h00;
        end else begin
            jobs_done_q <= jobs_done_d;
        end
    end

    assign jobs_done = jobs_done_q;
`endif

    assign alu_opcode  = opcode_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign result      = result_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_alu_job_scheduler.sv
// Scoreboard bench for alu_job_scheduler: expected results are queued when a
// job is pushed, and a negedge monitor pops and compares on result_valid.

module tb_alu_job_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [19:0] push_job;
    logic        alu_en;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [15:0] alu_result;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_product;
    logic [15:0] result;
    logic        result_valid;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        timeout_err;
    logic [3:0]  state;
`ifdef ALU_SCHED_STATS_EN
    logic [7:0]  jobs_done;
`endif

    alu_job_scheduler #(
        .DEPTH       (4),
        .MUL_OPCODE  (4'hF),
        .MUL_TIMEOUT (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_job     (push_job),
        .alu_en       (alu_en),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .mul_start    (mul_start),
        .mul_done     (mul_done),
        .mul_product  (mul_product),
        .result       (result),
        .result_valid (result_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .timeout_err  (timeout_err),
        .state        (state)
`ifdef ALU_SCHED_STATS_EN
        ,
        .jobs_done    (jobs_done)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];
    int rv_cyc_q [$];
    int cyc = 0;
    int alu_en_cnt = 0;
    int mul_start_cnt = 0;
    int rv_cnt = 0;
    int mw_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Simple ALU: 1 add, 2 sub, 3 and, 4 xor, else concatenation.
    always_comb begin
        case (alu_opcode)
            4'h1:    alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            4'h2:    alu_result = {8'h00, alu_a} - {8'h00, alu_b};
            4'h3:    alu_result = {8'h00, alu_a & alu_b};
            4'h4:    alu_result = {8'h00, alu_a ^ alu_b};
            default: alu_result = {alu_a, alu_b};
        endcase
    end

    // Multiplier model: answers mul_delay cycles after mul_start when enabled.
    bit mul_resp_en = 1'b1;
    int mul_delay = 8;
    bit mul_busy;
    int mul_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_busy    <= 1'b0;
            mul_cnt     <= 0;
            mul_done    <= 1'b0;
            mul_product <= 16'h0000;
        end else begin
            mul_done <= 1'b0;
            if (mul_start) begin
                mul_busy    <= 1'b1;
                mul_cnt     <= 1;
                mul_product <= alu_a * alu_b;
            end else if (mul_busy) begin
                if (mul_resp_en && mul_cnt >= mul_delay) begin
                    mul_done <= 1'b1;
                    mul_busy <= 1'b0;
                end else begin
                    mul_cnt <= mul_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) cyc++;

    // Monitor: scoreboard compare plus pulse bookkeeping.
    always @(negedge clk) begin
        if (reset) begin
            if (alu_en) alu_en_cnt++;
            if (mul_start) begin
                mul_start_cnt++;
                mw_cycles = 0;
            end
            if (state == 4'd3) mw_cycles++;
            if (result_valid) begin
                rv_cnt++;
                rv_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected result_valid", 32'(result), 32'hFFFFFFFF);
                end else begin
                    check("scoreboard result", 32'(result), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // All tasks assume entry at #1 after a rising edge.
    task automatic do_push(input logic [19:0] job);
        push     = 1'b1;
        push_job = job;
        @(posedge clk);
        #1;
        push = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            if (state == 4'd0 && empty) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_state(input string name, input logic [3:0] s, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            if (state == s) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check(name, 32'(state), 32'(s));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        mul_resp_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int a0, m0, r0;

    initial begin
        reset = 1'b0;
        push = 1'b0;
        push_job = 20'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset empty", 32'(empty), 32'd1);
        check("reset full", 32'(full), 32'd0);
        check("reset result", 32'(result), 32'h0);
        check("reset strobes", 32'({alu_en, mul_start, result_valid}), 32'd0);
        check("reset sticky", 32'({overflow, timeout_err}), 32'd0);
        check("reset issue regs", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU job: latency and pulse widths.
        a0 = alu_en_cnt;
        r0 = rv_cnt;
        exp_q.push_back(16'h0046);
        do_push({4'h1, 8'h12, 8'h34});
        check("A count after push", 32'(count), 32'd1);
        @(posedge clk);
        #1;
        check("A alu_en at N+1", 32'(alu_en), 32'd1);
        check("A result not yet", 32'(result), 32'h0);
        @(posedge clk);
        #1;
        check("A result at N+2", 32'(result), 32'h0046);
        check("A result_valid at N+2", 32'(result_valid), 32'd1);
        check("A alu_en dropped", 32'(alu_en), 32'd0);
        wait_drain("A drain", 20);
        check("A alu_en pulses", 32'(alu_en_cnt - a0), 32'd1);
        check("A result_valid pulses", 32'(rv_cnt - r0), 32'd1);
`ifdef ALU_SCHED_STATS_EN
        check("A jobs_done", 32'(jobs_done), 32'd1);
`endif

        // Back-to-back ALU jobs issue every 3 cycles.
        rv_cyc_q.delete();
        exp_q.push_back(16'h0033);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'hFFFF);
        do_push({4'h4, 8'h3C, 8'h0F});
        do_push({4'h1, 8'hFF, 8'h01});
        do_push({4'h2, 8'h00, 8'h01});
        wait_drain("G drain", 30);
        check("G result count", 32'(rv_cyc_q.size()), 32'd3);
        if (rv_cyc_q.size() == 3) begin
            check("G spacing 1", 32'(rv_cyc_q[1] - rv_cyc_q[0]), 32'd3);
            check("G spacing 2", 32'(rv_cyc_q[2] - rv_cyc_q[1]), 32'd3);
        end

        // Multiplier job answered after 8 cycles.
        m0 = mul_start_cnt;
        mul_delay = 8;
        exp_q.push_back(16'h0078);
        do_push({4'hF, 8'h0C, 8'h0A});
        wait_drain("B drain", 40);
        check("B mul_start pulses", 32'(mul_start_cnt - m0), 32'd1);
        check("B result", 32'(result), 32'h0078);
        check("B timeout_err", 32'(timeout_err), 32'd0);
        check("B scoreboard empty", 32'(exp_q.size()), 32'd0);

        // Multiplier never answers: timeout, then next job is served.
        mul_resp_en = 1'b0;
        exp_q.push_back(16'hDEAD);
        exp_q.push_back(16'h0015);
        do_push({4'hF, 8'h11, 8'h11});
        do_push({4'h1, 8'h0A, 8'h0B});
        wait_drain("C drain", 60);
        check("C timeout_err", 32'(timeout_err), 32'd1);
        check("C cycles in MUL_WAIT", 32'(mw_cycles), 32'd32);
        check("C next job result", 32'(result), 32'h0015);
        check("C scoreboard empty", 32'(exp_q.size()), 32'd0);
`ifdef ALU_SCHED_STATS_EN
        check("C jobs_done", 32'(jobs_done), 32'd7);
`endif

        // Overflow while held in MUL_WAIT.
        do_reset();
        check("D timeout_err cleared", 32'(timeout_err), 32'd0);
        mul_resp_en = 1'b0;
        exp_q.push_back(16'h000F);
        do_push({4'hF, 8'h03, 8'h05});
        wait_state("D reach MUL_WAIT", 4'd3, 10);
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h000D);
        exp_q.push_back(16'h0030);
        exp_q.push_back(16'h00FF);
        do_push({4'h1, 8'h01, 8'h02});
        do_push({4'h2, 8'h10, 8'h03});
        do_push({4'h3, 8'hF0, 8'h3C});
        do_push({4'h4, 8'hAA, 8'h55});
        check("D full after 4", 32'(full), 32'd1);
        check("D count after 4", 32'(count), 32'd4);
        check("D no overflow yet", 32'(overflow), 32'd0);
        do_push({4'h1, 8'h77, 8'h77});
        check("D overflow after 5th", 32'(overflow), 32'd1);
        check("D count after 5th", 32'(count), 32'd4);
        mul_resp_en = 1'b1;
        wait_drain("D drain", 60);
        check("D scoreboard empty", 32'(exp_q.size()), 32'd0);
        check("D overflow sticky", 32'(overflow), 32'd1);
        check("D no timeout", 32'(timeout_err), 32'd0);

        // Push into a full FIFO on the cycle IDLE pops.
        do_reset();
        check("E overflow cleared", 32'(overflow), 32'd0);
        mul_resp_en = 1'b0;
        exp_q.push_back(16'h0006);
        do_push({4'hF, 8'h02, 8'h03});
        wait_state("E reach MUL_WAIT", 4'd3, 10);
        exp_q.push_back(16'h0042);
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'h000F);
        exp_q.push_back(16'h00FF);
        do_push({4'h1, 8'h20, 8'h22});
        do_push({4'h2, 8'h05, 8'h07});
        do_push({4'h3, 8'h0F, 8'hFF});
        do_push({4'h4, 8'h0F, 8'hF0});
        mul_resp_en = 1'b1;
        wait_state("E reach WRITEBACK", 4'd4, 40);
        @(posedge clk);
        #1;
        check("E idle with full fifo", 32'({state, full}), 32'({4'd0, 1'b1}));
        exp_q.push_back(16'h0002);
        do_push({4'h1, 8'h01, 8'h01});
        check("E count stays 4", 32'(count), 32'd4);
        check("E overflow stays 0", 32'(overflow), 32'd0);
        check("E popped to ALU_ISSUE", 32'(state), 32'd1);
        wait_drain("E drain", 60);
        check("E scoreboard empty", 32'(exp_q.size()), 32'd0);
        check("E last result", 32'(result), 32'h0002);

        // Reset in MUL_WAIT with 3 jobs queued.
        mul_resp_en = 1'b0;
        do_push({4'hF, 8'h04, 8'h04});
        wait_state("F reach MUL_WAIT", 4'd3, 10);
        do_push({4'h1, 8'h01, 8'h01});
        do_push({4'h2, 8'h09, 8'h01});
        do_push({4'h3, 8'hFF, 8'h0F});
        check("F count before reset", 32'(count), 32'd3);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("F state after reset", 32'(state), 32'd0);
        check("F count after reset", 32'(count), 32'd0);
        check("F result after reset", 32'(result), 32'h0);
        check("F strobes after reset", 32'({alu_en, mul_start, result_valid}), 32'd0);
`ifdef ALU_SCHED_STATS_EN
        check("F jobs_done after reset", 32'(jobs_done), 32'd0);
`endif
        a0 = alu_en_cnt;
        m0 = mul_start_cnt;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mul_resp_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("F no alu_en after reset", 32'(alu_en_cnt - a0), 32'd0);
        check("F no mul_start after reset", 32'(mul_start_cnt - m0), 32'd0);
        check("F idle and empty", 32'({state, empty}), 32'({4'd0, 1'b1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
